// File: rtl/cmp_stream.sv
// Streaming multi-lane signed comparator: per-lane mask per beat plus per-column
// match count / any / all reductions, with valid/ready flow control.
module cmp_stream #(
  parameter int NUM_SIZE      = 32,
  parameter int LANES         = 4,
  parameter int CMD_SIZE_LOG2 = 3,
  parameter int CNT_W         = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*NUM_SIZE-1:0] s_in1,
  input  logic [LANES*NUM_SIZE-1:0] s_in2,
  input  logic [LANES-1:0]          s_keep,
  input  logic                      s_last,
  input  logic [CMD_SIZE_LOG2-1:0]  s_cmd,
  input  logic                      s_use_scalar,
  input  logic [NUM_SIZE-1:0]       s_scalar,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES-1:0]          m_mask,
  output logic                      m_last,
  output logic                      cnt_valid,
  output logic [CNT_W-1:0]          cnt,
  output logic                      any,
  output logic                      all,
  output logic                      err
);
  localparam int STAGES = 2;
  typedef logic [CMD_SIZE_LOG2-1:0] cmd_t;
  localparam cmd_t OP_EQ = cmd_t'(0);
  localparam cmd_t OP_NE = cmd_t'(1);
  localparam cmd_t OP_LT = cmd_t'(2);
  localparam cmd_t OP_LE = cmd_t'(3);
  localparam cmd_t OP_GT = cmd_t'(4);
  localparam cmd_t OP_GE = cmd_t'(5);

  logic [STAGES:1]     vld_pipe;
  logic                rdy_en;
  logic                in_col;
  cmd_t                cfg_cmd, cur_cmd;
  logic                cfg_use, cur_use;
  logic [NUM_SIZE-1:0] cfg_scalar, cur_scalar;
  logic                accept, s2_adv, xfer;
  logic [LANES-1:0]    cmp, s1_mask, s1_keep, s2_keep;
  logic                s1_last;

  // First beat of a column compares with its own config; later beats use the latched copy.
  assign cur_cmd    = in_col ? cfg_cmd    : s_cmd;
  assign cur_use    = in_col ? cfg_use    : s_use_scalar;
  assign cur_scalar = in_col ? cfg_scalar : s_scalar;

  assign s2_adv  = vld_pipe[1] && (!vld_pipe[2] || m_ready);
  assign s_ready = rdy_en && !(vld_pipe[1] && vld_pipe[2] && !m_ready);
  assign accept  = s_valid && s_ready;
  assign xfer    = vld_pipe[2] && m_ready;
  assign m_valid = vld_pipe[2];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [NUM_SIZE-1:0] a, b;
    logic                       hit;
    assign a = s_in1[i*NUM_SIZE +: NUM_SIZE];
    assign b = cur_use ? cur_scalar : s_in2[i*NUM_SIZE +: NUM_SIZE];
    always_comb begin
      hit = 1'b0;
      case (cur_cmd)
        OP_EQ:   hit = (a == b);
        OP_NE:   hit = (a != b);
        OP_LT:   hit = (a <  b);
        OP_LE:   hit = (a <= b);
        OP_GT:   hit = (a >  b);
        OP_GE:   hit = (a >= b);
        default: hit = 1'b0;
      endcase
    end
    assign cmp[i] = hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en     <= 1'b0;
      in_col     <= 1'b0;
      cfg_cmd    <= '0;
      cfg_use    <= 1'b0;
      cfg_scalar <= '0;
      err        <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        in_col <= !s_last;
        if (!in_col) begin
          cfg_cmd    <= s_cmd;
          cfg_use    <= s_use_scalar;
          cfg_scalar <= s_scalar;
        end
        if (cur_cmd > OP_GE) err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_mask  <= '0;
      s1_keep  <= '0;
      s1_last  <= 1'b0;
      m_mask   <= '0;
      m_last   <= 1'b0;
      s2_keep  <= '0;
    end else begin
      if (accept) begin
        vld_pipe[1] <= 1'b1;
        s1_mask     <= cmp & s_keep;
        s1_keep     <= s_keep;
        s1_last     <= s_last;
      end else if (s2_adv) begin
        vld_pipe[1] <= 1'b0;
      end
      // S2 only reloads on advance, so the mask holds while stalled.
      if (s2_adv) begin
        vld_pipe[2] <= 1'b1;
        m_mask      <= s1_mask;
        m_last      <= s1_last;
        s2_keep     <= s1_keep;
      end else if (m_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  logic [CNT_W-1:0] acc_cnt, cnt_next;
  logic [CNT_W:0]   pop, cnt_sum;
  logic             acc_any, acc_all, any_next, all_next;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + {{CNT_W{1'b0}}, m_mask[i]};
    cnt_sum  = {1'b0, acc_cnt} + pop;
    cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    any_next = acc_any | (|m_mask);
    all_next = acc_all & (m_mask == s2_keep);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt   <= '0;
      acc_any   <= 1'b0;
      acc_all   <= 1'b1;
      cnt       <= '0;
      any       <= 1'b0;
      all       <= 1'b1;
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= xfer && m_last;
      if (xfer) begin
        if (m_last) begin
          cnt     <= cnt_next;
          any     <= any_next;
          all     <= all_next;
          acc_cnt <= '0;
          acc_any <= 1'b0;
          acc_all <= 1'b1;
        end else begin
          acc_cnt <= cnt_next;
          acc_any <= any_next;
          acc_all <= all_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_cmp_stream.sv
// Bench for cmp_stream: directed scenarios plus randomized backpressure against a
// beat/column-level reference model; a CNT_W=4 twin covers counter saturation.
module tb_cmp_stream;
  localparam int W = 32, L = 4, CW = 3;

  logic             clk = 1'b0, reset = 1'b1;
  logic             s_valid = 1'b0, s_ready, s_last = 1'b0, s_use_scalar = 1'b0;
  logic [L*W-1:0]   s_in1 = '0, s_in2 = '0;
  logic [L-1:0]     s_keep = '0;
  logic [CW-1:0]    s_cmd = '0;
  logic [W-1:0]     s_scalar = '0;
  logic             m_valid, m_ready = 1'b1, m_last, cnt_valid, any, all, err;
  logic [L-1:0]     m_mask;
  logic [31:0]      cnt;
  logic             sat_s_ready, sat_m_valid, sat_m_last, sat_cv, sat_any, sat_all, sat_err;
  logic [L-1:0]     sat_m_mask;
  logic [3:0]       sat_cnt;

  cmp_stream #(.NUM_SIZE(W), .LANES(L), .CMD_SIZE_LOG2(CW), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_in1(s_in1),
    .s_in2(s_in2), .s_keep(s_keep), .s_last(s_last), .s_cmd(s_cmd),
    .s_use_scalar(s_use_scalar), .s_scalar(s_scalar), .m_valid(m_valid),
    .m_ready(m_ready), .m_mask(m_mask), .m_last(m_last), .cnt_valid(cnt_valid),
    .cnt(cnt), .any(any), .all(all), .err(err));

  cmp_stream #(.NUM_SIZE(W), .LANES(L), .CMD_SIZE_LOG2(CW), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(sat_s_ready), .s_in1(s_in1),
    .s_in2(s_in2), .s_keep(s_keep), .s_last(s_last), .s_cmd(s_cmd),
    .s_use_scalar(s_use_scalar), .s_scalar(s_scalar), .m_valid(sat_m_valid),
    .m_ready(m_ready), .m_mask(sat_m_mask), .m_last(sat_m_last), .cnt_valid(sat_cv),
    .cnt(sat_cnt), .any(sat_any), .all(sat_all), .err(sat_err));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  typedef struct { logic [L-1:0] mask; logic last; } beat_t;
  typedef struct { longint c; logic a_any; logic a_all; } rep_t;
  beat_t exp_q[$];
  rep_t  rep_q[$];

  bit          col_open = 0, muse = 0, many = 0, mall = 1;
  int          mcmd = 0;
  logic [W-1:0] mscalar = '0;
  longint      mcnt = 0;
  int          n_acc = 0, n_xfer = 0;
  bit          exp_cv = 0, stall_prev = 0, bp_en = 0;
  logic [L-1:0] prev_mask = '0;
  logic        prev_last = 1'b0;

  always @(posedge clk) begin
    #1 m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic bit ref_cmp(int op, longint a, longint b);
    case (op)
      0: return a == b;
      1: return a != b;
      2: return a <  b;
      3: return a <= b;
      4: return a >  b;
      5: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [L*W-1:0] pack4(int a0, int a1, int a2, int a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic model_accept(input logic [L*W-1:0] in1, input logic [L*W-1:0] in2,
                              input logic [L-1:0] keep, input bit last, input int cmd,
                              input bit use_sc, input logic [W-1:0] scalar);
    beat_t b;
    rep_t  r;
    logic [W-1:0] x, y;
    if (!col_open) begin
      mcmd = cmd; muse = use_sc; mscalar = scalar; col_open = 1;
    end
    for (int i = 0; i < L; i++) begin
      x = in1[i*W +: W];
      y = muse ? mscalar : in2[i*W +: W];
      b.mask[i] = keep[i] && ref_cmp(mcmd, longint'($signed(x)), longint'($signed(y)));
    end
    b.last = last;
    exp_q.push_back(b);
    mcnt = mcnt + $countones(b.mask);
    if (mcnt > 64'hFFFF_FFFF) mcnt = 64'hFFFF_FFFF;
    many = many | (|b.mask);
    mall = mall & (b.mask == keep);
    if (last) begin
      r.c = mcnt; r.a_any = many; r.a_all = mall;
      rep_q.push_back(r);
      mcnt = 0; many = 0; mall = 1; col_open = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [L*W-1:0] in1, input logic [L*W-1:0] in2,
                           input logic [L-1:0] keep, input bit last, input int cmd,
                           input bit use_sc, input logic [W-1:0] scalar);
    bit ok = 0;
    s_valid = 1; s_in1 = in1; s_in2 = in2; s_keep = keep; s_last = last;
    s_cmd = cmd[CW-1:0]; s_use_scalar = use_sc; s_scalar = scalar;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin ok = 1; break; end
    end
    if (ok) begin
      model_accept(in1, in2, keep, last, cmd, use_sc, scalar);
      @(posedge clk); #1;
      n_acc++;
    end else begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: s_ready=%b, required 1 within 200 cycles", s_ready);
    end
    s_valid = 0;
  endtask

  task automatic wait_cv(output bit got);
    got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (cnt_valid === 1'b1) begin got = 1; break; end
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); rep_q.delete();
    col_open = 0; mcnt = 0; many = 0; mall = 1;
    n_acc = 0; n_xfer = 0; exp_cv = 0; stall_prev = 0;
  endtask

  always @(negedge clk) begin
    beat_t b;
    rep_t  r;
    if (reset === 1'b0) begin
      if (n_acc - n_xfer >= 2 && m_ready === 1'b0) begin
        n_chk++;
        if (s_ready !== 1'b0) begin
          n_fail++; $display("FAIL s_ready_full: s_ready=%b, required 0", s_ready);
        end
      end
      if (stall_prev) begin
        n_chk++;
        if (m_mask !== prev_mask || m_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_stable: mask=%b last=%b, required mask=%b last=%b",
                   m_mask, m_last, prev_mask, prev_last);
        end
      end
      if (exp_cv || cnt_valid === 1'b1) begin
        n_chk++;
        if (cnt_valid !== exp_cv) begin
          n_fail++; $display("FAIL cnt_valid_timing: cnt_valid=%b, required %b", cnt_valid, exp_cv);
        end
      end
      if (cnt_valid === 1'b1) begin
        n_chk++;
        if (rep_q.size() == 0) begin
          n_fail++; $display("FAIL report_extra: cnt_valid=1, required no report");
        end else begin
          r = rep_q.pop_front();
          if (cnt !== r.c[31:0] || any !== r.a_any || all !== r.a_all) begin
            n_fail++;
            $display("FAIL report: cnt=%0d any=%b all=%b, required cnt=%0d any=%b all=%b",
                     cnt, any, all, r.c, r.a_any, r.a_all);
          end
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL beat_extra: mask=%b, required no beat", m_mask);
        end else begin
          b = exp_q.pop_front();
          if (m_mask !== b.mask || m_last !== b.last) begin
            n_fail++;
            $display("FAIL beat: mask=%b last=%b, required mask=%b last=%b",
                     m_mask, m_last, b.mask, b.last);
          end
        end
        n_xfer++;
      end
      exp_cv     = (m_valid === 1'b1 && m_ready === 1'b1 && m_last === 1'b1);
      stall_prev = (m_valid === 1'b1 && m_ready === 1'b0);
      prev_mask  = m_mask;
      prev_last  = m_last;
    end
  end

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({s_ready, m_valid, m_mask, m_last, cnt_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: s_ready=%b m_valid=%b mask=%b last=%b cv=%b, required all 0",
               s_ready, m_valid, m_mask, m_last, cnt_valid);
    end
    n_chk++;
    if (cnt !== 0 || any !== 0 || all !== 1 || err !== 0) begin
      n_fail++;
      $display("FAIL reset_red: cnt=%0d any=%b all=%b err=%b, required 0 0 1 0", cnt, any, all, err);
    end
    @(posedge clk); #1 reset = 0;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: s_ready=%b, required 1", s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vector();
    send_beat(pack4(-1, 5, 0, 7), pack4(0, 5, -3, 8), 4'hF, 1, 2, 0, '0);
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL vec_early: m_valid=%b at N+1, required 0", m_valid);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1'b1 || m_mask !== 4'b1001) begin
      n_fail++; $display("FAIL vec_mask: m_valid=%b mask=%b, required 1 1001", m_valid, m_mask);
    end
    @(negedge clk);
    n_chk++;
    if (cnt_valid !== 1'b1 || cnt !== 2 || any !== 1 || all !== 0) begin
      n_fail++;
      $display("FAIL vec_report: cv=%b cnt=%0d any=%b all=%b, required 1 2 1 0",
               cnt_valid, cnt, any, all);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_scalar();
    logic [L-1:0] k;
    int  tot = 0;
    bit  got;
    for (int i = 0; i < 3; i++) begin
      k = 4'($urandom);
      tot += $countones(k);
      // Beat 2 carries a different opcode and no scalar; the column must ignore both.
      send_beat({$urandom, $urandom, $urandom, $urandom}, '0, k, i == 2,
                (i == 1) ? 0 : 5, i != 1, 32'h8000_0000);
    end
    wait_cv(got);
    n_chk++;
    if (!got || cnt !== tot || any !== (tot > 0) || all !== 1'b1) begin
      n_fail++;
      $display("FAIL scalar_ge: got=%b cnt=%0d any=%b all=%b, required cnt=%0d any=%b all=1",
               got, cnt, any, all, tot, tot > 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_keep_empty();
    bit got;
    send_beat(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 4'b0000, 1, 0, 0, '0);
    wait_cv(got);
    n_chk++;
    if (!got || cnt !== 0 || any !== 0 || all !== 1) begin
      n_fail++;
      $display("FAIL empty_col: got=%b cnt=%0d any=%b all=%b, required 0 0 1", got, cnt, any, all);
    end
    @(posedge clk); #1;
    send_beat(pack4(9, -9, 3, 4), pack4(9, -9, 0, 0), 4'b0011, 1, 0, 0, '0);
    wait_cv(got);
    n_chk++;
    if (!got || cnt !== 2 || any !== 1 || all !== 1) begin
      n_fail++;
      $display("FAIL keep_eq: got=%b cnt=%0d any=%b all=%b, required 2 1 1", got, cnt, any, all);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [L*W-1:0] a, b;
    bit drained = 0;
    bp_en = 1;
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < L; j++) if ($urandom_range(0, 1)) b[j*W +: W] = a[j*W +: W];
      send_beat(a, b, 4'($urandom), (i % 5 == 4) || (i == 15), $urandom_range(0, 5),
                $urandom_range(0, 1), (i % 2) ? a[W-1:0] : $urandom);
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rep_q.size() == 0) begin drained = 1; break; end
    end
    bp_en = 0;
    n_chk++;
    if (!drained) begin
      n_fail++;
      $display("FAIL bp_drain: %0d beats %0d reports left, required 0 0", exp_q.size(), rep_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reserved_reset();
    bit got;
    send_beat(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 4'hF, 0, 7, 0, '0);
    send_beat(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 4'hF, 1, 0, 0, '0);
    wait_cv(got);
    n_chk++;
    if (!got || cnt !== 0 || err !== 1'b1) begin
      n_fail++; $display("FAIL reserved: got=%b cnt=%0d err=%b, required cnt=0 err=1", got, cnt, err);
    end
    @(posedge clk); #1;
    send_beat(pack4(5, 6, 7, 8), pack4(5, 0, 7, 0), 4'hF, 1, 0, 0, '0);
    wait_cv(got);
    n_chk++;
    if (!got || cnt !== 2 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got=%b cnt=%0d err=%b, required cnt=2 err=1", got, cnt, err);
    end
    @(posedge clk); #1;
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'hF, 0, 0, 0, '0);
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'hF, 0, 0, 0, '0);
    #2 reset = 1;
    #1;
    n_chk++;
    if ({s_ready, m_valid, m_mask, m_last, cnt_valid, any, err} !== '0 || cnt !== 0 || all !== 1) begin
      n_fail++;
      $display("FAIL mid_reset: rdy=%b mv=%b mask=%b cv=%b cnt=%0d any=%b all=%b err=%b, required reset values",
               s_ready, m_valid, m_mask, cnt_valid, cnt, any, all, err);
    end
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (4) @(posedge clk);
    #1;
    send_beat(pack4(3, -4, 5, 6), pack4(3, -4, 0, 6), 4'b1011, 1, 0, 0, '0);
    wait_cv(got);
    n_chk++;
    if (!got || cnt !== 3 || any !== 1 || all !== 1) begin
      n_fail++;
      $display("FAIL post_reset: got=%b cnt=%0d any=%b all=%b, required 3 1 1", got, cnt, any, all);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bit got;
    for (int i = 0; i < 5; i++)
      send_beat(pack4(i, i, i, i), pack4(i, i, i, i), 4'hF, i == 4, 0, 0, '0);
    wait_cv(got);
    n_chk++;
    if (!got || sat_cv !== 1'b1 || sat_cnt !== 4'd15 || cnt !== 20) begin
      n_fail++;
      $display("FAIL saturation: got=%b sat_cv=%b sat_cnt=%0d cnt=%0d, required 1 1 15 20",
               got, sat_cv, sat_cnt, cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_scalar();
    test_keep_empty();
    test_backpressure();
    test_reserved_reset();
    test_saturation();
    repeat (5) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0 || rep_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d beats %0d reports, required 0 0", exp_q.size(), rep_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmp_stream.md
# cmp_stream

Streaming, multi-lane signed comparator for column filtering: compares LANES packed elements per beat against a second column or a broadcast scalar and emits a per-lane boolean mask. Also accumulates per-column reductions: match count, any, all. Sits between the column DMA reader and the mask writer, and generalises the single-pair, single-bit comparator to vectors, valid/ready flow control and column framing.

## Interface

- NUM_SIZE, 32, element width in bits (signed two's complement)
- LANES, 4, elements per beat (1..16)
- CMD_SIZE_LOG2, 3, width of the encoded opcode field
- CNT_W, 32, width of the match counter
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_in1  in  LANES*NUM_SIZE  left operands; lane i in bits [i*NUM_SIZE +: NUM_SIZE]
- s_in2  in  LANES*NUM_SIZE  right operands, ignored in scalar mode
- s_keep  in  LANES  lane-valid bits; an unkept lane yields mask 0 and is excluded from reductions
- s_last  in  1  final beat of a column
- s_cmd  in  CMD_SIZE_LOG2  opcode, sampled on the first beat of a column
- s_use_scalar  in  1  compare against s_scalar instead of s_in2, sampled with s_cmd
- s_scalar  in  NUM_SIZE  broadcast right operand, sampled with s_cmd
- m_valid  out  1  mask beat valid
- m_ready  in  1  downstream accepts the mask beat
- m_mask  out  LANES  per-lane result
- m_last  out  1  copy of s_last for the beat
- cnt_valid  out  1  one-cycle pulse: column reductions are valid
- cnt  out  CNT_W  number of true kept lanes in the column (saturating)
- any  out  1  at least one kept lane true
- all  out  1  every kept lane true
- err  out  1  sticky: a reserved opcode was seen

## Operation

- Opcodes: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6–7 reserved. Reserved opcodes force the mask to 0 for the whole column and set err.
- Comparisons are full-width signed. No truncation or extension; operands are exactly NUM_SIZE.
- Column framing: the first accepted beat after reset, or after an accepted s_last beat, starts a column. On that beat s_cmd, s_use_scalar and s_scalar are latched and held until the column's s_last beat. Changes mid-column are ignored.
- A one-beat column (s_last on the first beat) uses that beat's config.
- Pipeline has 2 stages:
  - S1 registers the lane compare results ANDed with s_keep, plus keep and last.
  - S2 registers m_mask and m_last and updates the accumulators.
- Accumulators update when the S2 beat transfers (m_valid && m_ready).
  - cnt += popcount(mask), saturating at 2^CNT_W−1.
  - any |= |mask.
  - all &= (mask == keep).
- On the transfer of the m_last beat, the final values are presented on cnt/any/all with cnt_valid=1 for one cycle. The accumulators then clear to cnt=0, any=0, all=1.
- A column whose every lane is unkept reports cnt=0, any=0, all=1.
- cnt/any/all hold their last reported values until the next report. cnt_valid has no backpressure.
- err is cleared only by reset.

## Timing

- Reset values: s_ready=0 while reset is asserted and 1 from the first cycle after deassertion. m_valid=0, m_mask=0, m_last=0, cnt_valid=0, cnt=0, any=0, all=1, err=0. Pipeline is empty and the column state is "start".
- Latency: an input accepted in cycle N appears on m_valid/m_mask in cycle N+2 when m_ready is held high.
- Throughput: 1 beat/cycle sustained.
- s_ready = !(S1 full && S2 full && !m_ready). There is no combinational path from s_valid to s_ready.
- Backpressure: while m_ready=0 the pipeline fills and s_ready drops after two accepted beats. No beat is lost or duplicated. m_mask and m_last are stable while m_valid && !m_ready.
- cnt_valid asserts in the cycle after the m_last handshake, with the values already registered.
- If a new column's first beat transfers in the same cycle as the old column's report, the two columns do not mix: the new column starts from cleared accumulators.
- Reset mid-column:
  - Immediately clears all state and in-flight beats.
  - No cnt_valid is produced for the partial column.
  - The next accepted beat starts a new column.

## Test plan

- Vector compare: LANES=4, cmd=2 (LT), in1={-1,5,0,7}, in2={0,5,−3,8}, keep=4'hF, last=1 -> m_mask=4'b1001 (lane0 in bit 0) at N+2. Then cnt=2, any=1, all=0, with cnt_valid one cycle after the handshake.
- Scalar mode: use_scalar=1, scalar=−2^31, cmd=5 (GE), 3-beat column with random in1 -> every kept mask bit is 1 and cnt equals the number of kept lanes. Change cmd on beat 2 -> no effect.
- Keep and empty column: keep=4'b0000 on a single last beat -> m_mask=0, cnt=0, any=0, all=1. Then keep=4'b0011 with EQ true on both lanes -> all=1, cnt=2.
- Backpressure: stream 16 beats with m_ready toggling randomly -> output order and masks match the model, s_ready never high with both stages full and m_ready low, and m_mask stays stable while stalled.
- Reserved opcode and reset: cmd=7 column -> mask 0 and err=1 persisting into the next EQ column. Assert reset mid-column -> all outputs return to reset values and no cnt_valid is produced. A next column of one beat reports correctly.
- Saturation: CNT_W=4, LANES=4, five all-true beats -> cnt=15.
